// File: rtl/layer_cache_pkg.sv
// Shared types and width helpers for the per-layer line cache.
package layer_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        RESP
    } cache_state_t;

    function automatic int ofs_width(input int line_depth);
        return $clog2(line_depth);
    endfunction

    function automatic int tag_width(input int addr_width, input int line_depth);
        return addr_width - $clog2(line_depth);
    endfunction

    function automatic int layer_width(input int max_layers);
        return $clog2(max_layers);
    endfunction

endpackage

// File: rtl/layer_line_cache_if.sv
// Read-client, SDRAM-fill and invalidate signals of the layer line cache.
// master: layer RAM stage plus SDRAM side; slave: the cache itself.
interface layer_line_cache_if
    import layer_cache_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH_WORDS = 24,
    parameter int MAX_LAYERS       = 32
);
    localparam int LAYER_W = layer_width(MAX_LAYERS);

    logic                        rd_req;
    logic [LAYER_W-1:0]          rd_layer;
    logic [ADDR_WIDTH_WORDS-1:0] rd_addr;
    logic                        rd_ready;
    logic [DATA_WIDTH-1:0]       rd_data;
    logic                        rd_valid;
    logic                        mem_req;
    logic [ADDR_WIDTH_WORDS-1:0] mem_addr;
    logic                        mem_ack;
    logic [DATA_WIDTH-1:0]       mem_data;
    logic                        mem_data_valid;
    logic                        inv_req;
    logic [LAYER_W-1:0]          inv_layer;

    modport master (
        output rd_req, rd_layer, rd_addr, mem_ack, mem_data, mem_data_valid,
               inv_req, inv_layer,
        input  rd_ready, rd_data, rd_valid, mem_req, mem_addr
    );

    modport slave (
        input  rd_req, rd_layer, rd_addr, mem_ack, mem_data, mem_data_valid,
               inv_req, inv_layer,
        output rd_ready, rd_data, rd_valid, mem_req, mem_addr
    );

endinterface

// File: rtl/layer_cache_mem.sv
// Simple dual-port line storage: one write port, one registered read port
// (the read register gives the cache its one-cycle hit latency).
module layer_cache_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/layer_line_cache.sv
// Per-layer single-line read cache in front of the SDRAM controller.
// Optional hit/miss counters are enabled with LAYER_CACHE_STATS_EN.
module layer_line_cache
    import layer_cache_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH_WORDS = 24,
    parameter int LINE_DEPTH       = 32,
    parameter int MAX_LAYERS       = 32
) (
    input  logic               clk,
    input  logic               rst,
    layer_line_cache_if.slave  bus
`ifdef LAYER_CACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);
    localparam int OFS_W   = ofs_width(LINE_DEPTH);
    localparam int TAG_W   = tag_width(ADDR_WIDTH_WORDS, LINE_DEPTH);
    localparam int LAYER_W = layer_width(MAX_LAYERS);

    cache_state_t        state, next_state;
    logic [MAX_LAYERS-1:0] valid;
    logic [TAG_W-1:0]    tags [MAX_LAYERS];
    logic [LAYER_W-1:0]  lat_layer;
    logic [TAG_W-1:0]    lat_tag;
    logic [OFS_W-1:0]    lat_ofs;
    logic [OFS_W-1:0]    beat_cnt;
    logic                kill;
    logic                rd_valid_q;

    logic [TAG_W-1:0]    req_tag;
    logic [OFS_W-1:0]    req_ofs;
    logic                accept, hit, miss, beat, last_beat;

    assign req_tag   = bus.rd_addr[ADDR_WIDTH_WORDS-1:OFS_W];
    assign req_ofs   = bus.rd_addr[OFS_W-1:0];
    assign accept    = bus.rd_req && (state == IDLE);
    // A same-cycle invalidate of the requested layer forces a miss.
    assign hit       = accept && valid[bus.rd_layer] && (tags[bus.rd_layer] == req_tag)
                       && !(bus.inv_req && (bus.inv_layer == bus.rd_layer));
    assign miss      = accept && !hit;
    assign beat      = (state == FILL) && bus.mem_data_valid;
    assign last_beat = beat && (beat_cnt == OFS_W'(LINE_DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (miss)        next_state = REQ;
            REQ:     if (bus.mem_ack) next_state = FILL;
            FILL:    if (last_beat)   next_state = RESP;
            RESP:                     next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.rd_ready = (state == IDLE);
        bus.mem_req  = (state == REQ);
        bus.mem_addr = (state == REQ) ? {lat_tag, {OFS_W{1'b0}}} : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_layer  <= '0;
            lat_tag    <= '0;
            lat_ofs    <= '0;
            beat_cnt   <= '0;
            kill       <= 1'b0;
            rd_valid_q <= 1'b0;
            valid      <= '0;
        end else begin
            rd_valid_q <= hit || (state == RESP);
            if (miss) begin
                lat_layer <= bus.rd_layer;
                lat_tag   <= req_tag;
                lat_ofs   <= req_ofs;
                kill      <= 1'b0;
            end
            if ((state == REQ) && bus.mem_ack) beat_cnt <= '0;
            if (beat)                          beat_cnt <= beat_cnt + 1'b1;
            if ((state == REQ || state == FILL) && bus.inv_req && (bus.inv_layer == lat_layer))
                kill <= 1'b1;
            if (last_beat && !kill) valid[lat_layer] <= 1'b1;
            // Invalidate is applied last so it wins over a same-edge line completion.
            if (bus.inv_req) valid[bus.inv_layer] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (last_beat) tags[lat_layer] <= lat_tag;
    end

    layer_cache_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_LAYERS * LINE_DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (beat),
        .waddr ({lat_layer, beat_cnt}),
        .wdata (bus.mem_data),
        .re    (hit || (state == RESP)),
        .raddr ((state == RESP) ? {lat_layer, lat_ofs} : {bus.rd_layer, req_ofs}),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid = rd_valid_q;

`ifdef LAYER_CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
            if (miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_layer_line_cache.sv
// Self-checking bench for layer_line_cache: directed vector table, hand
// sequences for invalidate/reset corner cases, then randomized reads.
module tb_layer_line_cache;
    import layer_cache_pkg::*;

    localparam int DW = 16;
    localparam int AW = 24;
    localparam int LD = 32;
    localparam int ML = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_line_cache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH_WORDS(AW), .MAX_LAYERS(ML)) bus ();

`ifdef LAYER_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    layer_line_cache #(
        .DATA_WIDTH       (DW),
        .ADDR_WIDTH_WORDS (AW),
        .LINE_DEPTH       (LD),
        .MAX_LAYERS       (ML)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef LAYER_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which line each layer holds, plus expected statistics.
    bit            mvalid [ML];
    logic [AW-6:0] mtag   [ML];
    int            exp_hits   = 0;
    int            exp_misses = 0;

    typedef struct {
        int          layer;
        logic [23:0] addr;
        int          kill_beat;
        bit          exp_miss;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SDRAM contents: a fixed function of the word address.
    function automatic logic [15:0] mem_word(input logic [23:0] a);
        return a[15:0] + 16'h0FC0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
`ifdef LAYER_CACHE_STATS_EN
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
`endif
    endtask

    task automatic do_read(input int layer, input logic [23:0] addr, input bit inv_at_req,
                           input int kill_beat, input bit exp_miss, input logic [15:0] exp_data);
        logic [23:0] base;
        base = addr & 24'hFFFFE0;
        check("rd_ready_idle", {31'b0, bus.rd_ready}, 1);
        bus.rd_req   = 1'b1;
        bus.rd_layer = 5'(layer);
        bus.rd_addr  = addr;
        if (inv_at_req) begin
            bus.inv_req   = 1'b1;
            bus.inv_layer = 5'(layer);
        end
        cyc();
        bus.rd_req  = 1'b0;
        bus.inv_req = 1'b0;
        if (inv_at_req) mvalid[layer] = 1'b0;
        if (!exp_miss) begin
            exp_hits++;
            check("hit_valid", {31'b0, bus.rd_valid}, 1);
            check("hit_data", {16'b0, bus.rd_data}, {16'b0, exp_data});
            check("hit_no_mem_req", {31'b0, bus.mem_req}, 0);
        end else begin
            exp_misses++;
            check("miss_mem_req", {31'b0, bus.mem_req}, 1);
            check("miss_mem_addr", {8'b0, bus.mem_addr}, {8'b0, base});
            check("miss_rd_ready", {31'b0, bus.rd_ready}, 0);
            check("miss_no_valid", {31'b0, bus.rd_valid}, 0);
            // Junk beats while waiting for ack must be ignored.
            repeat ($urandom_range(0, 3)) begin
                bus.mem_data_valid = 1'($urandom_range(0, 1));
                bus.mem_data       = 16'($urandom);
                cyc();
            end
            bus.mem_data_valid = 1'b0;
            bus.mem_ack = 1'b1;
            cyc();
            bus.mem_ack = 1'b0;
            check("ack_drops_req", {31'b0, bus.mem_req}, 0);
            for (int i = 0; i < LD; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.mem_data_valid = 1'b0;
                    bus.mem_data       = 16'($urandom);
                    cyc();
                end
                bus.mem_data_valid = 1'b1;
                bus.mem_data       = mem_word(base + 24'(i));
                if (i == kill_beat) begin
                    bus.inv_req   = 1'b1;
                    bus.inv_layer = 5'(layer);
                end
                cyc();
                bus.inv_req = 1'b0;
            end
            bus.mem_data_valid = 1'b0;
            check("resp_not_early", {31'b0, bus.rd_valid}, 0);
            cyc();
            check("miss_valid", {31'b0, bus.rd_valid}, 1);
            check("miss_data", {16'b0, bus.rd_data}, {16'b0, exp_data});
            check("ready_back", {31'b0, bus.rd_ready}, 1);
            mvalid[layer] = (kill_beat < 0);
            mtag[layer]   = addr[23:5];
        end
    endtask

    task automatic model_read(input int layer, input logic [23:0] addr, input bit inv_at_req,
                              input int kill_beat);
        bit m;
        m = inv_at_req || !(mvalid[layer] && (mtag[layer] == addr[23:5]));
        do_read(layer, addr, inv_at_req, kill_beat, m, mem_word(addr));
    endtask

    task automatic do_inv(input int layer);
        bus.inv_req   = 1'b1;
        bus.inv_layer = 5'(layer);
        cyc();
        bus.inv_req = 1'b0;
        mvalid[layer] = 1'b0;
        check("inv_ready", {31'b0, bus.rd_ready}, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_ready"}, {31'b0, bus.rd_ready}, 1);
        check({tag, "_rd_valid"}, {31'b0, bus.rd_valid}, 0);
        check({tag, "_rd_data"}, {16'b0, bus.rd_data}, 0);
        check({tag, "_mem_req"}, {31'b0, bus.mem_req}, 0);
        check({tag, "_mem_addr"}, {8'b0, bus.mem_addr}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3,  24'h000045, -1, 1'b1, 16'h1005};
        vecs[1]  = '{3,  24'h00005F, -1, 1'b0, 16'h101F};
        vecs[2]  = '{4,  24'h000100, -1, 1'b1, 16'h10C0};
        vecs[3]  = '{3,  24'h000060, -1, 1'b1, 16'h1020};
        vecs[4]  = '{4,  24'h00011F, -1, 1'b0, 16'h10DF};
        vecs[5]  = '{3,  24'h000041, -1, 1'b1, 16'h1001};
        vecs[6]  = '{5,  24'h000205, 10, 1'b1, 16'h11C5};
        vecs[7]  = '{5,  24'h000205, -1, 1'b1, 16'h11C5};
        vecs[8]  = '{5,  24'h000206, -1, 1'b0, 16'h11C6};
        vecs[9]  = '{6,  24'hFFFFFF, -1, 1'b1, 16'h0FBF};
        vecs[10] = '{6,  24'hFFFFE0, -1, 1'b0, 16'h0FA0};
        vecs[11] = '{31, 24'h000000, -1, 1'b1, 16'h0FC0};

        bus.rd_req = 1'b0; bus.rd_layer = '0; bus.rd_addr = '0;
        bus.mem_ack = 1'b0; bus.mem_data = '0; bus.mem_data_valid = 1'b0;
        bus.inv_req = 1'b0; bus.inv_layer = '0;
        for (int i = 0; i < ML; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end
        rst = 1'b1;
        repeat (2) cyc();
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc();
        check_stats();

        // First miss, then the whole line back-to-back as hits.
        do_read(vecs[0].layer, vecs[0].addr, 1'b0, vecs[0].kill_beat, vecs[0].exp_miss, vecs[0].exp_data);
        for (int i = 0; i < LD; i++)
            do_read(3, 24'h000040 + 24'(i), 1'b0, -1, 1'b0, 16'h1000 + 16'(i));
        cyc();
        check("hit_pulse_ends", {31'b0, bus.rd_valid}, 0);

        for (int v = 1; v < 12; v++) begin
            do_read(vecs[v].layer, vecs[v].addr, 1'b0, vecs[v].kill_beat, vecs[v].exp_miss, vecs[v].exp_data);
            if (v == 7) check_stats();
            cyc();
        end

        // Request and invalidate to the same valid layer in one cycle: miss.
        do_read(5, 24'h000206, 1'b1, -1, 1'b1, 16'h11C6);
        cyc();
        check_stats();

        // Reset in the middle of a fill.
        bus.rd_req = 1'b1; bus.rd_layer = 5'd7; bus.rd_addr = 24'h000300;
        cyc();
        bus.rd_req = 1'b0;
        check("rstfill_mem_req", {31'b0, bus.mem_req}, 1);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data       = mem_word(24'h000300 + 24'(i));
            cyc();
        end
        bus.mem_data = mem_word(24'h00030A);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_reset_outputs("midfill");
        for (int i = 0; i < ML; i++) mvalid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        check_stats();
        for (int i = 11; i < LD + 3; i++) begin
            bus.mem_data_valid = (i < LD);
            bus.mem_data       = mem_word(24'h000300 + 24'(i));
            cyc();
            check("post_rst_no_valid", {31'b0, bus.rd_valid}, 0);
            check("post_rst_no_req", {31'b0, bus.mem_req}, 0);
        end
        bus.mem_data_valid = 1'b0;
        check("post_rst_ready", {31'b0, bus.rd_ready}, 1);
        model_read(7, 24'h000300, 1'b0, -1);
        model_read(3, 24'h000061, 1'b0, -1);
        check_stats();

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            int r;
            int l;
            logic [23:0] a;
            r = int'($urandom_range(0, 9));
            l = int'($urandom_range(0, 7));
            a = {17'b0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
            if (r == 0) do_inv(l);
            else model_read(l, a, r == 1, (r == 2) ? int'($urandom_range(0, 31)) : -1);
            if ($urandom_range(0, 2) == 0) cyc();
        end
        cyc();
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
